vga_timing_gen: RTL and testbench



---
 rtl/vga_pkg.sv | 31 +++
 rtl/vga_if.sv | 13 +
 rtl/vga_axis_cnt.sv | 64 ++++++
 rtl/vga_timing_gen.sv | 140 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared XGA (1024x768@60) raster timing constants for the video pipeline.
// Draw stages import these so their notion of the raster matches the generator.
package vga_pkg;

  localparam int COUNT_W = 11;

  localparam int H_ACTIVE = 1024;
  localparam int H_FP     = 24;
  localparam int H_SYNC   = 136;
  localparam int H_BP     = 160;

  localparam int V_ACTIVE = 768;
  localparam int V_FP     = 3;
  localparam int V_SYNC   = 6;
  localparam int V_BP     = 29;

  localparam logic HSYNC_POL = 1'b0;
  localparam logic VSYNC_POL = 1'b0;

  function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int H_TOTAL      = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL      = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

endpackage

// File: rtl/vga_if.sv
// Raster bundle passed along the video pipeline; the timing generator drives it.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/vga_axis_cnt.sv
// One raster axis: modulo counter with terminal-count flag and registered
// blank/sync decode taken from the next count, so flags align with the count.
module vga_axis_cnt
  import vga_pkg::*;
#(
  parameter int   ACTIVE = 1024,
  parameter int   FP     = 24,
  parameter int   SYNC   = 136,
  parameter int   BP     = 160,
  parameter logic POL    = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic [COUNT_W-1:0] cnt,
  output logic               wrap,
  output logic               blnk,
  output logic               sync
);

  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
  localparam logic [COUNT_W-1:0] LAST_C       = COUNT_W'(TOTAL - 1);
  localparam logic [COUNT_W-1:0] ACTIVE_C     = COUNT_W'(ACTIVE);
  localparam logic [COUNT_W-1:0] SYNC_START_C = COUNT_W'(ACTIVE + FP);
  localparam logic [COUNT_W-1:0] SYNC_END_C   = COUNT_W'(ACTIVE + FP + SYNC);

  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic               blnk_q, blnk_d;
  logic               sync_q, sync_d;
  logic               at_last_s;

  assign at_last_s = (cnt_q == LAST_C);

  always_comb begin
    cnt_d  = cnt_q;
    blnk_d = blnk_q;
    sync_d = sync_q;
    if (rst) begin
      cnt_d  = '0;
      blnk_d = 1'b0;
      sync_d = ~POL;
    end else begin
      if (en) begin
        cnt_d = at_last_s ? '0 : cnt_q + {{(COUNT_W-1){1'b0}}, 1'b1};
      end else begin
        cnt_d = cnt_q;
      end
      blnk_d = (cnt_d >= ACTIVE_C);
      sync_d = ((cnt_d >= SYNC_START_C) && (cnt_d < SYNC_END_C)) ? POL : ~POL;
    end
  end

  always_ff @(posedge clk) begin
    cnt_q  <= cnt_d;
    blnk_q <= blnk_d;
    sync_q <= sync_d;
  end

  assign cnt  = cnt_q;
  assign wrap = at_last_s;
  assign blnk = blnk_q;
  assign sync = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster source for the video pipeline: pixel/line counters, blank/sync, line and
// frame pulses. Define VGA_FRAME_CNT_EN to build the completed-frame counter.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE  = vga_pkg::H_ACTIVE,
  parameter int   H_FP      = vga_pkg::H_FP,
  parameter int   H_SYNC    = vga_pkg::H_SYNC,
  parameter int   H_BP      = vga_pkg::H_BP,
  parameter int   V_ACTIVE  = vga_pkg::V_ACTIVE,
  parameter int   V_FP      = vga_pkg::V_FP,
  parameter int   V_SYNC    = vga_pkg::V_SYNC,
  parameter int   V_BP      = vga_pkg::V_BP,
  parameter logic HSYNC_POL = vga_pkg::HSYNC_POL,
  parameter logic VSYNC_POL = vga_pkg::VSYNC_POL
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  vga_if.out          vout,
  output logic        line_start,
  output logic        frame_start,
  output logic [15:0] frame_cnt
);

  localparam int H_TOT = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOT = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if ((H_TOT > (1 << COUNT_W)) || (V_TOT > (1 << COUNT_W))) begin : g_bad_cfg
    $fatal(1, "vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 2048");
  end

  logic [COUNT_W-1:0] h_cnt_s, v_cnt_s;
  logic               h_wrap_s, v_wrap_s;
  logic               h_blnk_s, v_blnk_s, h_sync_s, v_sync_s;
  logic               h_adv_s, v_adv_s, frame_wrap_s;

  logic started_q, started_d;
  logic line_start_q, line_start_d;
  logic frame_start_q, frame_start_d;

  // The first enabled cycle after reset presents (0,0) with both pulses rather than advancing.
  assign h_adv_s      = en & started_q;
  assign v_adv_s      = h_adv_s & h_wrap_s;
  assign frame_wrap_s = v_adv_s & v_wrap_s;

  vga_axis_cnt #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (HSYNC_POL)
  ) u_h_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (h_adv_s),
    .cnt  (h_cnt_s),
    .wrap (h_wrap_s),
    .blnk (h_blnk_s),
    .sync (h_sync_s)
  );

  vga_axis_cnt #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (VSYNC_POL)
  ) u_v_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (v_adv_s),
    .cnt  (v_cnt_s),
    .wrap (v_wrap_s),
    .blnk (v_blnk_s),
    .sync (v_sync_s)
  );

  always_comb begin
    started_d     = started_q;
    line_start_d  = line_start_q;
    frame_start_d = frame_start_q;
    if (rst) begin
      started_d     = 1'b0;
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;
    end else if (en) begin
      started_d     = 1'b1;
      line_start_d  = ~started_q | h_wrap_s;
      frame_start_d = ~started_q | (h_wrap_s & v_wrap_s);
    end else begin
      started_d     = started_q;
      line_start_d  = line_start_q;
      frame_start_d = frame_start_q;
    end
  end

  always_ff @(posedge clk) begin
    started_q     <= started_d;
    line_start_q  <= line_start_d;
    frame_start_q <= frame_start_d;
  end

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (rst) begin
      frame_cnt_d = 16'd0;
    end else if (frame_wrap_s) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end else begin
      frame_cnt_d = frame_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    frame_cnt_q <= frame_cnt_d;
  end

  assign frame_cnt = frame_cnt_q;
`else
  logic unused_frame_wrap_s;
  assign unused_frame_wrap_s = frame_wrap_s;
  assign frame_cnt = 16'd0;
`endif

  assign vout.hcount = h_cnt_s;
  assign vout.vcount = v_cnt_s;
  assign vout.hblnk  = h_blnk_s;
  assign vout.vblnk  = v_blnk_s;
  assign vout.hsync  = h_sync_s;
  assign vout.vsync  = v_sync_s;
  assign vout.rgb    = 12'd0;

  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default XGA instance for line-level checks, and a tiny-raster
// instance (16x12 total, active-high syncs) for full-frame and wrap checks.
module tb_vga_timing_gen;

  logic        clk = 1'b0;
  logic        rst_a, en_a, rst_b, en_b;
  logic        ls_a, fs_a, ls_b, fs_b;
  logic [15:0] fc_a, fc_b;
  int          checks = 0;
  int          errors = 0;
  int          hs_low;

  vga_if vif_a ();
  vga_if vif_b ();

  always #5 clk = ~clk;

  vga_timing_gen dut_a (
    .clk         (clk),
    .rst         (rst_a),
    .en          (en_a),
    .vout        (vif_a),
    .line_start  (ls_a),
    .frame_start (fs_a),
    .frame_cnt   (fc_a)
  );

  vga_timing_gen #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
    .V_ACTIVE (6), .V_FP (1), .V_SYNC (2), .V_BP (3),
    .HSYNC_POL (1'b1), .VSYNC_POL (1'b1)
  ) dut_b (
    .clk         (clk),
    .rst         (rst_b),
    .en          (en_b),
    .vout        (vif_b),
    .line_start  (ls_b),
    .frame_start (fs_b),
    .frame_cnt   (fc_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input int h, input int v, input bit hb, input bit hs,
                       input bit vb, input bit vs, input bit ls, input bit fs);
    chk({tag, ".hcount"}, 32'(vif_a.hcount), 32'(h));
    chk({tag, ".vcount"}, 32'(vif_a.vcount), 32'(v));
    chk({tag, ".hblnk"}, 32'(vif_a.hblnk), 32'(hb));
    chk({tag, ".hsync"}, 32'(vif_a.hsync), 32'(hs));
    chk({tag, ".vblnk"}, 32'(vif_a.vblnk), 32'(vb));
    chk({tag, ".vsync"}, 32'(vif_a.vsync), 32'(vs));
    chk({tag, ".line_start"}, 32'(ls_a), 32'(ls));
    chk({tag, ".frame_start"}, 32'(fs_a), 32'(fs));
    chk({tag, ".rgb"}, 32'(vif_a.rgb), 32'd0);
  endtask

  task automatic chk_b(input string tag, input int h, input int v, input bit ls, input bit fs);
    chk({tag, ".hcount"}, 32'(vif_b.hcount), 32'(h));
    chk({tag, ".vcount"}, 32'(vif_b.vcount), 32'(v));
    chk({tag, ".hblnk"}, 32'(vif_b.hblnk), 32'(h >= 8));
    chk({tag, ".hsync"}, 32'(vif_b.hsync), 32'((h >= 10) && (h < 13)));
    chk({tag, ".vblnk"}, 32'(vif_b.vblnk), 32'(v >= 6));
    chk({tag, ".vsync"}, 32'(vif_b.vsync), 32'((v >= 7) && (v < 9)));
    chk({tag, ".line_start"}, 32'(ls_b), 32'(ls));
    chk({tag, ".frame_start"}, 32'(fs_b), 32'(fs));
  endtask

  initial begin
    rst_a = 1'b1; en_a = 1'b0;
    rst_b = 1'b1; en_b = 1'b0;
    step();
    // Reset state: syncs sit at their inactive level.
    chk_a("rst_a", 0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("rst_a.frame_cnt", 32'(fc_a), 32'd0);
    chk_b("rst_b", 0, 0, 1'b0, 1'b0);
    chk("rst_b.frame_cnt", 32'(fc_b), 32'd0);

    // Small raster: one complete frame, every pixel checked.
    rst_b = 1'b0; en_b = 1'b1;
    for (int v = 0; v < 12; v++) begin
      for (int h = 0; h < 16; h++) begin
        step();
        chk_b("frame_b", h, v, (h == 0), (h == 0) && (v == 0));
        chk("frame_b.frame_cnt", 32'(fc_b), 32'd0);
      end
    end
    step();
    chk_b("wrap_b", 0, 0, 1'b1, 1'b1);
`ifdef VGA_FRAME_CNT_EN
    chk("wrap_b.frame_cnt", 32'(fc_b), 32'd1);
`else
    chk("wrap_b.frame_cnt", 32'(fc_b), 32'd0);
`endif
    en_b = 1'b0;
    step();
    chk_b("hold_b", 0, 0, 1'b1, 1'b1);
    step();
    chk_b("hold2_b", 0, 0, 1'b1, 1'b1);

    // Default raster: line 0 horizontal decode.
    rst_a = 1'b0; en_a = 1'b1;
    step();
    chk_a("first_a", 0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    hs_low = 0;
    for (int h = 1; h < 1344; h++) begin
      step();
      chk_a("line0_a", h, 0, (h >= 1024), !((h >= 1048) && (h < 1184)), 1'b0, 1'b1, 1'b0, 1'b0);
      if (vif_a.hsync == 1'b0) hs_low++;
    end
    chk("line0_a.hsync_width", 32'(hs_low), 32'd136);
    step();
    chk_a("line1_a", 0, 1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);

    // Enable gating around hcount 500.
    for (int h = 1; h < 500; h++) step();
    chk("pre_gate_a.hcount", 32'(vif_a.hcount), 32'd499);
    en_a = 1'b1; step();
    chk("gate1_a.hcount", 32'(vif_a.hcount), 32'd500);
    en_a = 1'b0; step();
    chk("gate2_a.hcount", 32'(vif_a.hcount), 32'd500);
    chk("gate2_a.line_start", 32'(ls_a), 32'd0);
    step();
    chk("gate3_a.hcount", 32'(vif_a.hcount), 32'd500);
    en_a = 1'b1; step();
    chk("gate4_a.hcount", 32'(vif_a.hcount), 32'd501);
    chk("gate4_a.line_start", 32'(ls_a), 32'd0);

    // Run to (700,2) then reset mid-frame.
    for (int i = 0; i < 1543; i++) step();
    chk_a("mid_a", 700, 2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    rst_a = 1'b1;
    step();
    chk_a("midrst_a", 0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("midrst_a.frame_cnt", 32'(fc_a), 32'd0);
    rst_a = 1'b0;
    step();
    chk_a("resume0_a", 0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    step();
    chk_a("resume1_a", 1, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
